divider_seq_restoring: RTL and testbench

//   Unsigned sequential restoring divider (shift-subtract). It is the inverse-operation

---
 rtl/divider_seq_restoring.sv | 122 ++++++++++++
 tb/tb_divider_seq_restoring.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_restoring.sv
// Unsigned sequential restoring divider: one quotient bit per cycle, MSB first,
// with valid/ready handshakes on the operand and result sides.
module divider_seq_restoring #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);
  // state | meaning
  // IDLE  | waiting for operands, in_rdy high
  // CALC  | one shift-subtract iteration per cycle, DW cycles
  // DONE  | result presented, held until out_rdy
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_r;
  logic [DW-1:0] q_sr;
  logic [DW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo_r;
  logic [DW-1:0] rem_r;
  logic          dbz_r;

  logic [DW:0]   t;
  logic [DW:0]   diff;
  logic          ge;
  logic [DW-1:0] q_nxt;
  logic [DW-1:0] rem_nxt;
  logic          last;
  logic          accept;

  // rem < divisor always holds, so t < 2*divisor and the borrow of the
  // DW+1 bit subtraction is exactly the (t < divisor) decision.
  assign t       = {rem, q_sr[DW-1]};
  assign diff    = t - {1'b0, div_r};
  assign ge      = ~diff[DW];
  assign q_nxt   = {q_sr[DW-2:0], ge};
  assign rem_nxt = ge ? diff[DW-1:0] : t[DW-1:0];
  assign last    = (cnt == CW'(DW - 1));
  assign accept  = in_vld && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
      q_sr  <= '0;
      rem   <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      div_r <= divisor;
      q_sr  <= dividend;
      rem   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
      if (divisor == '0) begin
        quo_r <= '1;
        rem_r <= dividend;
        dbz_r <= 1'b1;
      end
    end else if (state == CALC) begin
      q_sr <= q_nxt;
      rem  <= rem_nxt;
      cnt  <= cnt + 1'b1;
      if (last) begin
        quo_r <= q_nxt;
        rem_r <= rem_nxt;
      end
    end
  end

  assign quotient    = quo_r;
  assign remainder   = rem_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Bench for divider_seq_restoring: DW=4 table, corner sequences and exhaustive
// sweep, plus a DW=8 random sweep, all checked through expected-result queues.
module tb_divider_seq_restoring;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0, out_rdy = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic       in_rdy, out_vld, div_by_zero;
  logic [3:0] quotient, remainder;

  logic       in_vld8 = 1'b0, out_rdy8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic       in_rdy8, out_vld8, div_by_zero8;
  logic [7:0] quotient8, remainder8;

  int   total = 0;
  int   bad = 0;
  logic rand_rdy = 1'b0;
  vec_t exp4, exp8;
  vec_t sb4[$];
  vec_t sb8[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  divider_seq_restoring #(.DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .dividend(dividend), .divisor(divisor), .out_vld(out_vld), .out_rdy(out_rdy),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  divider_seq_restoring #(.DW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld8), .in_rdy(in_rdy8),
    .dividend(dividend8), .divisor(divisor8), .out_vld(out_vld8), .out_rdy(out_rdy8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  function automatic vec_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 0) begin
      v.q = (w == 4) ? 8'h0f : 8'hff;
      v.r = a;
      v.z = 1'b1;
    end else begin
      v.q = a / b;
      v.r = a % b;
      v.z = 1'b0;
    end
    return v;
  endfunction

  // Called at a negedge: records what the next rising edge will accept or
  // complete, then advances one cycle and returns at the following negedge.
  task automatic tick();
    vec_t e;
    if (in_vld && in_rdy) sb4.push_back(exp4);
    if (out_vld && out_rdy) begin
      if (sb4.size() == 0) begin
        total++; bad++;
        $display("FAIL sb4_unexpected q=%0d r=%0d", quotient, remainder);
      end else begin
        e = sb4.pop_front();
        chk($sformatf("q4 %0d/%0d", e.a, e.b), quotient, e.q);
        chk($sformatf("r4 %0d/%0d", e.a, e.b), remainder, e.r);
        chk($sformatf("z4 %0d/%0d", e.a, e.b), div_by_zero, e.z);
      end
    end
    if (in_vld8 && in_rdy8) sb8.push_back(exp8);
    if (out_vld8 && out_rdy8) begin
      if (sb8.size() == 0) begin
        total++; bad++;
        $display("FAIL sb8_unexpected q=%0d r=%0d", quotient8, remainder8);
      end else begin
        e = sb8.pop_front();
        chk($sformatf("q8 %0d/%0d", e.a, e.b), quotient8, e.q);
        chk($sformatf("r8 %0d/%0d", e.a, e.b), remainder8, e.r);
        chk($sformatf("z8 %0d/%0d", e.a, e.b), div_by_zero8, e.z);
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
    out_rdy8 = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic op4(input vec_t v);
    int n = 0;
    dividend = v.a[3:0];
    divisor  = v.b[3:0];
    exp4     = v;
    in_vld   = 1'b1;
    while (!in_rdy && n < 40) begin tick(); n++; end
    if (!in_rdy) begin
      total++; bad++;
      $display("FAIL accept4_timeout %0d/%0d", v.a, v.b);
    end
    tick();
    in_vld = 1'b0;
  endtask

  task automatic op8(input vec_t v);
    int n = 0;
    dividend8 = v.a;
    divisor8  = v.b;
    exp8      = v;
    in_vld8   = 1'b1;
    while (!in_rdy8 && n < 40) begin tick(); n++; end
    if (!in_rdy8) begin
      total++; bad++;
      $display("FAIL accept8_timeout %0d/%0d", v.a, v.b);
    end
    tick();
    in_vld8 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0 || out_vld || out_vld8) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", sb4.size() + sb8.size(), 0);
  endtask

  initial begin
    tbl[0] = '{8'd15, 8'd1, 8'd15, 8'd0, 1'b0};
    tbl[1] = '{8'd5,  8'd7, 8'd0,  8'd5, 1'b0};
    tbl[2] = '{8'd0,  8'd9, 8'd0,  8'd0, 1'b0};
    tbl[3] = '{8'd13, 8'd3, 8'd4,  8'd1, 1'b0};
    tbl[4] = '{8'd9,  8'd0, 8'd15, 8'd9, 1'b1};
    tbl[5] = '{8'd6,  8'd2, 8'd3,  8'd0, 1'b0};
    tbl[6] = '{8'd8,  8'd3, 8'd2,  8'd2, 1'b0};
    tbl[7] = '{8'd14, 8'd5, 8'd2,  8'd4, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    // 13/3 latency: accept edge 0, out_vld first seen after edge 4
    out_rdy = 1'b0;
    op4(tbl[3]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lat_low_%0d", i), out_vld, 0);
      tick();
    end
    chk("lat_high", out_vld, 1);
    out_rdy = 1'b1;
    drain();

    // divide by zero: result the cycle after accept, then a normal op clears the flag
    out_rdy = 1'b0;
    op4(tbl[4]);
    chk("dbz_out_vld", out_vld, 1);
    chk("dbz_flag", div_by_zero, 1);
    out_rdy = 1'b1;
    drain();
    op4(tbl[5]);
    drain();

    // 8/3 with the consumer stalled for 5 cycles
    out_rdy = 1'b0;
    op4(tbl[6]);
    for (int n = 0; n < 20 && !out_vld; n++) tick();
    dividend = 4'd1;
    divisor  = 4'd1;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1;
      chk("stall_out_vld", out_vld, 1);
      chk("stall_q", quotient, 2);
      chk("stall_r", remainder, 2);
      chk("stall_in_rdy", in_rdy, 0);
      tick();
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    chk("hs_in_rdy", in_rdy, 0);
    tick();
    out_rdy = 1'b0;
    chk("post_hs_in_rdy", in_rdy, 1);
    chk("post_hs_out_vld", out_vld, 0);
    chk("post_hs_q_held", quotient, 2);

    // reset before iteration 2 of 14/5 discards it
    op4(tbl[7]);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_in_rdy", in_rdy, 1);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    sb4.delete();
    tick();
    rst_n = 1'b1;
    op4(tbl[7]);
    out_rdy = 1'b1;
    drain();

    // table vectors with random consumer back-pressure and idle gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      op4(tbl[i]);
    end
    drain();

    // exhaustive DW=4 sweep against a/b and a%b
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 1)) tick();
        op4(model(4, 8'(a), 8'(b)));
      end
    end
    drain();

    // DW=8 random sweep, including some zero and full-scale divisors
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a8, b8;
      a8 = 8'($urandom_range(0, 255));
      b8 = (i % 25 == 0) ? 8'd0 : (i % 25 == 1) ? 8'hff : 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 1)) tick();
      op8(model(8, a8, b8));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
